sysbus_arbiter: RTL and testbench
=================================

# sysbus_arbiter

Two-port arbiter that shares the single system-bus master interface between the instruction cache (port 0) and the data cache (port 1). It grants one cache-line read transaction at a time, forwards the granted requester's request phase to the bus, and steers the response burst back to that requester only. It sits between the two caches and the top-level bus pins, and each cache keeps its own bus-facing handshake unchanged.

## Interface
Parameters:
- BUS_DATA_WIDTH, 64, width of request address/data and response beats
- BUS_TAG_WIDTH, 13, width of request/response tags
- BEATS, 8, response beats per transaction (512-bit line / 64-bit bus)

Ports (px = p0 or p1; p0 = icache, p1 = dcache):
- clk  in  1  single clock; all state updates on posedge
- reset  in  1  asynchronous, active-high; clears all state immediately
- px_reqcyc  in  1  requester wants the bus; held until px_reqack
- px_req  in  BUS_DATA_WIDTH  request address
- px_reqtag  in  BUS_TAG_WIDTH  request tag
- px_reqack  out  1  bus_reqack forwarded to the granted port only
- px_respcyc  out  1  bus_respcyc forwarded to the granted port only
- px_resp  out  BUS_DATA_WIDTH  bus_resp forwarded to the granted port, 0 otherwise
- px_resptag  out  BUS_TAG_WIDTH  bus_resptag forwarded to the granted port, 0 otherwise
- px_respack  in  1  response-beat acknowledge from requester
- px_grant  out  1  registered; port owns the bus
- bus_reqcyc  out  1  to bus
- bus_req  out  BUS_DATA_WIDTH  to bus
- bus_reqtag  out  BUS_TAG_WIDTH  to bus
- bus_respack  out  1  to bus
- bus_reqack  in  1  from bus
- bus_respcyc  in  1  from bus
- bus_resp  in  BUS_DATA_WIDTH  from bus
- bus_resptag  in  BUS_TAG_WIDTH  from bus

## Operation
- State machine states: IDLE, REQ, RESP.
  - IDLE: no grant. If any px_reqcyc is high, register a grant and go to REQ.
  - REQ: drive bus_reqcyc=1, bus_req=px_req and bus_reqtag=px_reqtag of the granted port. On bus_reqack=1, forward the ack to the granted port, clear the beat counter, and go to RESP.
  - RESP: bus_reqcyc=0. bus_respack = px_respack of the granted port. A beat is counted when bus_respcyc & bus_respack. When the BEATS-th beat is counted, drop the grant and go to IDLE.
- Arbitration is round-robin with a last-grant pointer. Both requesting → grant the port that is not last-granted. Single requester → grant it regardless of the pointer. The pointer updates when a grant is issued.
- The non-granted port sees reqack=0, respcyc=0, resp=0 and resptag=0. Its reqcyc is ignored and it keeps waiting.
- A beat counter of width clog2(BEATS)+1 counts 0..BEATS and clears on entry to RESP.
- bus_respcyc dropping before BEATS beats: stay in RESP and keep counting. Beats are not required to be contiguous.
- px_reqcyc deasserting while in REQ before bus_reqack: the request is already committed to the bus. Stay in REQ and keep presenting the latched address/tag, which is captured into a register at grant time.

## Timing
- Reset values: state=IDLE, grant=none, pointer=port 1 (so port 0 wins the first tie), counter=0. All outputs are 0: bus_reqcyc, bus_req, bus_reqtag, bus_respack, px_grant, px_reqack, px_respcyc, px_resp, px_resptag.
- Reset asserted mid-transaction: everything returns to reset values asynchronously. The bus transaction is abandoned, and requesters must re-request.
- Grant latency: px_reqcyc high at edge N (sampled in IDLE) gives px_grant=1 and bus_reqcyc=1 from cycle N+1.
- Request-phase outputs (bus_reqcyc, bus_req, bus_reqtag) are registered/latched.
- Response-path forwarding (reqack, respcyc, resp, resptag, respack) is combinational, with zero added latency.
- The last beat is counted at edge M, so state=IDLE and px_grant=0 in cycle M+1. A new grant follows no earlier than M+2, giving one idle bus cycle between transactions.
- Request arriving during REQ or RESP: it is held off. The requester's reqcyc stays high and it is served at the next IDLE per round-robin.

## Test plan
- Single icache request: p0_reqcyc=1 with addr 0x1000. Required: bus_req=0x1000 one cycle later. Ack after 2 cycles, then 8 beats 0x0..0x7. Required: p0_resp carries exactly those 8 values, p1 sees zeros, and p0_grant drops the cycle after beat 8.
- Simultaneous requests out of reset: p0 addr 0x2000, p1 addr 0x3000. Required: p0 served first, then p1 (addresses appear on the bus in order 0x2000, 0x3000), with one idle cycle between them.
- Fairness: p0 and p1 both request continuously for 4 transactions. Required: grant order is 0,1,0,1.
- Gapped response: bus_respcyc low for 3 cycles between beats 4 and 5. Required: the arbiter stays in RESP, and the grant releases only after beat 8.
- Late request: p1 requests while p0 is in RESP beat 3. Required: p1 sees no reqack/respcyc until p0 finishes, and bus_req=p1 address in the cycle after IDLE.
- Reset mid-burst: reset asserted at beat 5. Required: all outputs are 0 immediately. After reset release, a pending p1 request is granted one cycle later.

Source files
------------

// File: rtl/sysbus_arbiter.sv
// rtl/sysbus_arbiter.sv - two-port round-robin arbiter for the system-bus master interface
//
// Shares one system-bus master between the icache (port 0) and the dcache
// (port 1). One cache-line read is in flight at a time: the winner's request
// is latched and presented on the bus, then the response burst is steered
// back to the winner only.
//
// Ports:
//   clk, reset                    clock, asynchronous active-high reset
//   p0_*/p1_* reqcyc/req/reqtag   request phase from each cache
//   p0_*/p1_* reqack              bus_reqack, granted port only
//   p0_*/p1_* respcyc/resp/resptag response burst, granted port only (0 otherwise)
//   p0_*/p1_* respack             beat acknowledge from each cache
//   p0_grant, p1_grant            registered ownership flags
//   bus_reqcyc/req/reqtag         latched request phase to the bus
//   bus_respack                   granted port's beat acknowledge to the bus
//   bus_reqack/respcyc/resp/resptag from the bus
module sysbus_arbiter #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int BEATS          = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      p0_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0] p0_req,
  input  logic [BUS_TAG_WIDTH-1:0]  p0_reqtag,
  output logic                      p0_reqack,
  output logic                      p0_respcyc,
  output logic [BUS_DATA_WIDTH-1:0] p0_resp,
  output logic [BUS_TAG_WIDTH-1:0]  p0_resptag,
  input  logic                      p0_respack,
  output logic                      p0_grant,
  input  logic                      p1_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0] p1_req,
  input  logic [BUS_TAG_WIDTH-1:0]  p1_reqtag,
  output logic                      p1_reqack,
  output logic                      p1_respcyc,
  output logic [BUS_DATA_WIDTH-1:0] p1_resp,
  output logic [BUS_TAG_WIDTH-1:0]  p1_resptag,
  input  logic                      p1_respack,
  output logic                      p1_grant,
  output logic                      bus_reqcyc,
  output logic [BUS_DATA_WIDTH-1:0] bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  output logic                      bus_respack,
  input  logic                      bus_reqack,
  input  logic                      bus_respcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag
);

  localparam int CNT_WIDTH = $clog2(BEATS) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                    state;
  state_t                    state_next;
  logic [1:0]                grant;       // one-hot: bit 0 = icache, bit 1 = dcache
  logic                      last_grant;  // port granted most recently
  logic [CNT_WIDTH-1:0]      beat_cnt;
  logic                      reqcyc_q;
  logic [BUS_DATA_WIDTH-1:0] req_q;
  logic [BUS_TAG_WIDTH-1:0]  reqtag_q;

  logic any_req;
  logic pick;       // port that wins arbitration this cycle
  logic beat;
  logic last_beat;

  always_comb begin
    any_req   = p0_reqcyc | p1_reqcyc;
    // On a tie the port that did not win last time goes next; a lone
    // requester wins regardless of the pointer.
    pick      = (p0_reqcyc & p1_reqcyc) ? ~last_grant : p1_reqcyc;
    beat      = (state == RESP) & bus_respcyc & bus_respack;
    last_beat = beat & (beat_cnt == CNT_WIDTH'(BEATS - 1));
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_req)    state_next = REQ;
      REQ:     if (bus_reqack) state_next = RESP;
      RESP:    if (last_beat)  state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  // Grant, pointer, latched request and beat counter. The request is
  // captured at grant time so a requester dropping reqcyc before the bus
  // acknowledges cannot change what is already committed to the bus.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant      <= 2'b00;
      last_grant <= 1'b1;
      beat_cnt   <= '0;
      reqcyc_q   <= 1'b0;
      req_q      <= '0;
      reqtag_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant      <= pick ? 2'b10 : 2'b01;
            last_grant <= pick;
            reqcyc_q   <= 1'b1;
            req_q      <= pick ? p1_req : p0_req;
            reqtag_q   <= pick ? p1_reqtag : p0_reqtag;
          end
        end
        REQ: begin
          if (bus_reqack) begin
            reqcyc_q <= 1'b0;
            beat_cnt <= '0;
          end
        end
        RESP: begin
          if (beat) begin
            beat_cnt <= beat_cnt + 1'b1;
          end
          if (last_beat) begin
            grant <= 2'b00;
          end
        end
        default: begin
          grant    <= 2'b00;
          reqcyc_q <= 1'b0;
        end
      endcase
    end
  end

  // Output logic: the response path is pure steering, gated by the grant,
  // so it adds no latency and a non-granted port always sees zeros.
  always_comb begin
    p0_grant    = grant[0];
    p1_grant    = grant[1];
    bus_reqcyc  = reqcyc_q;
    bus_req     = req_q;
    bus_reqtag  = reqtag_q;
    p0_reqack   = grant[0] & (state == REQ) & bus_reqack;
    p1_reqack   = grant[1] & (state == REQ) & bus_reqack;
    p0_respcyc  = grant[0] & bus_respcyc;
    p1_respcyc  = grant[1] & bus_respcyc;
    p0_resp     = grant[0] ? bus_resp : '0;
    p1_resp     = grant[1] ? bus_resp : '0;
    p0_resptag  = grant[0] ? bus_resptag : '0;
    p1_resptag  = grant[1] ? bus_resptag : '0;
    bus_respack = (state == RESP) &
                  ((grant[0] & p0_respack) | (grant[1] & p1_respack));
  end

endmodule

// File: tb/tb_sysbus_arbiter.sv
// tb/tb_sysbus_arbiter.sv - directed self-checking bench for sysbus_arbiter
module tb_sysbus_arbiter;

  localparam int DW = 64;
  localparam int TW = 13;

  logic          clk = 1'b0;
  logic          reset;
  logic          p0_reqcyc, p1_reqcyc;
  logic [DW-1:0] p0_req, p1_req;
  logic [TW-1:0] p0_reqtag, p1_reqtag;
  logic          p0_reqack, p1_reqack;
  logic          p0_respcyc, p1_respcyc;
  logic [DW-1:0] p0_resp, p1_resp;
  logic [TW-1:0] p0_resptag, p1_resptag;
  logic          p0_respack, p1_respack;
  logic          p0_grant, p1_grant;
  logic          bus_reqcyc;
  logic [DW-1:0] bus_req;
  logic [TW-1:0] bus_reqtag;
  logic          bus_respack;
  logic          bus_reqack;
  logic          bus_respcyc;
  logic [DW-1:0] bus_resp;
  logic [TW-1:0] bus_resptag;

  int n_chk  = 0;
  int n_fail = 0;

  sysbus_arbiter #(
    .BUS_DATA_WIDTH(DW),
    .BUS_TAG_WIDTH (TW),
    .BEATS         (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .p0_reqcyc  (p0_reqcyc),
    .p0_req     (p0_req),
    .p0_reqtag  (p0_reqtag),
    .p0_reqack  (p0_reqack),
    .p0_respcyc (p0_respcyc),
    .p0_resp    (p0_resp),
    .p0_resptag (p0_resptag),
    .p0_respack (p0_respack),
    .p0_grant   (p0_grant),
    .p1_reqcyc  (p1_reqcyc),
    .p1_req     (p1_req),
    .p1_reqtag  (p1_reqtag),
    .p1_reqack  (p1_reqack),
    .p1_respcyc (p1_respcyc),
    .p1_resp    (p1_resp),
    .p1_resptag (p1_resptag),
    .p1_respack (p1_respack),
    .p1_grant   (p1_grant),
    .bus_reqcyc (bus_reqcyc),
    .bus_req    (bus_req),
    .bus_reqtag (bus_reqtag),
    .bus_respack(bus_respack),
    .bus_reqack (bus_reqack),
    .bus_respcyc(bus_respcyc),
    .bus_resp   (bus_resp),
    .bus_resptag(bus_resptag)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic all_zero(input string tag);
    check({tag, "_bus_reqcyc"},  bus_reqcyc,  0);
    check({tag, "_bus_req"},     bus_req,     0);
    check({tag, "_bus_reqtag"},  bus_reqtag,  0);
    check({tag, "_bus_respack"}, bus_respack, 0);
    check({tag, "_p0_grant"},    p0_grant,    0);
    check({tag, "_p1_grant"},    p1_grant,    0);
    check({tag, "_p0_reqack"},   p0_reqack,   0);
    check({tag, "_p1_reqack"},   p1_reqack,   0);
    check({tag, "_p0_respcyc"},  p0_respcyc,  0);
    check({tag, "_p1_respcyc"},  p1_respcyc,  0);
    check({tag, "_p0_resp"},     p0_resp,     0);
    check({tag, "_p1_resp"},     p1_resp,     0);
    check({tag, "_p0_resptag"},  p0_resptag,  0);
    check({tag, "_p1_resptag"},  p1_resptag,  0);
  endtask

  task automatic clear_inputs();
    p0_reqcyc   = 1'b0; p1_reqcyc   = 1'b0;
    p0_req      = '0;   p1_req      = '0;
    p0_reqtag   = '0;   p1_reqtag   = '0;
    p0_respack  = 1'b0; p1_respack  = 1'b0;
    bus_reqack  = 1'b0; bus_respcyc = 1'b0;
    bus_resp    = '0;   bus_resptag = '0;
  endtask

  // Returns at a falling edge with reset just released.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    clear_inputs();
    #4;
    all_zero("reset");
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Plays the bus for one transaction. Called in the cycle before the grant
  // is expected; returns in the idle cycle that follows the last beat.
  // gap_at:   beat index preceded by 3 cycles of bus_respcyc=0 (-1 = none)
  // late_b:   beat index at which p1 starts requesting late_addr (-1 = none)
  // abort_at: beat index at which reset is pulsed mid-burst (-1 = none)
  task automatic serve(input int port, input logic [63:0] addr, input logic [12:0] tag,
                       input int gap_at, input bit keep, input int late_b,
                       input logic [63:0] late_addr, input int abort_at);
    logic [63:0] v;
    @(negedge clk);
    p0_respack = (port == 0);
    p1_respack = (port == 1);
    #4;
    check("grant",        port ? p1_grant : p0_grant, 1);
    check("other_grant",  port ? p0_grant : p1_grant, 0);
    check("bus_reqcyc",   bus_reqcyc, 1);
    check("bus_req",      bus_req, addr);
    check("bus_reqtag",   bus_reqtag, 64'(tag));
    @(negedge clk);
    #4;
    check("req_hold",     bus_reqcyc, 1);
    check("early_reqack", port ? p1_reqack : p0_reqack, 0);
    @(negedge clk);
    bus_reqack = 1'b1;
    #4;
    check("reqack",       port ? p1_reqack : p0_reqack, 1);
    check("other_reqack", port ? p0_reqack : p1_reqack, 0);
    @(negedge clk);
    bus_reqack = 1'b0;
    if (!keep) begin
      if (port == 0) p0_reqcyc = 1'b0;
      else           p1_reqcyc = 1'b0;
    end
    for (int b = 0; b < 8; b++) begin
      if (b == gap_at) begin
        for (int g = 0; g < 3; g++) begin
          bus_respcyc = 1'b0;
          #4;
          check("gap_grant",   port ? p1_grant : p0_grant, 1);
          check("gap_respcyc", port ? p1_respcyc : p0_respcyc, 0);
          @(negedge clk);
        end
      end
      if (b == late_b) begin
        p1_reqcyc = 1'b1;
        p1_req    = late_addr;
        p1_reqtag = 13'h19;
      end
      v = 64'(b) ^ (port ? 64'hD000_0000_0000_0000 : 64'h0);
      bus_respcyc = 1'b1;
      bus_resp    = v;
      bus_resptag = tag;
      if (b == abort_at) begin
        #2;
        reset = 1'b1;
        #1;
        all_zero("abort");
        bus_respcyc = 1'b0;
        bus_resp    = '0;
        bus_resptag = '0;
        @(negedge clk);
        reset = 1'b0;
        return;
      end
      #4;
      if (b == 0) check("resp_reqcyc", bus_reqcyc, 0);
      check("respcyc",       port ? p1_respcyc : p0_respcyc, 1);
      check("resp",          port ? p1_resp : p0_resp, v);
      check("resptag",       port ? p1_resptag : p0_resptag, 64'(tag));
      check("other_respcyc", port ? p0_respcyc : p1_respcyc, 0);
      check("other_resp",    port ? p0_resp : p1_resp, 0);
      check("other_resptag", port ? p0_resptag : p1_resptag, 0);
      check("other_reqack",  port ? p0_reqack : p1_reqack, 0);
      check("bus_respack",   bus_respack, 1);
      check("beat_grant",    port ? p1_grant : p0_grant, 1);
      @(negedge clk);
    end
    bus_respcyc = 1'b0;
    bus_resp    = '0;
    bus_resptag = '0;
    #4;
    check("release_p0_grant", p0_grant, 0);
    check("release_p1_grant", p1_grant, 0);
    check("idle_reqcyc",      bus_reqcyc, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    clear_inputs();
    do_reset();

    // Single icache request, response beats 0..7
    p0_reqcyc = 1'b1; p0_req = 64'h1000; p0_reqtag = 13'h11;
    #4;
    check("idle_grant", p0_grant, 0);
    serve(0, 64'h1000, 13'h11, -1, 1'b0, -1, 64'h0, -1);

    // Simultaneous requests out of reset: icache first, then dcache
    do_reset();
    p0_reqcyc = 1'b1; p0_req = 64'h2000; p0_reqtag = 13'h21;
    p1_reqcyc = 1'b1; p1_req = 64'h3000; p1_reqtag = 13'h31;
    #4;
    serve(0, 64'h2000, 13'h21, -1, 1'b0, -1, 64'h0, -1);
    serve(1, 64'h3000, 13'h31, -1, 1'b0, -1, 64'h0, -1);

    // Fairness: both request continuously, order 0,1,0,1
    do_reset();
    p0_reqcyc = 1'b1; p0_req = 64'h4000; p0_reqtag = 13'h40;
    p1_reqcyc = 1'b1; p1_req = 64'h4100; p1_reqtag = 13'h41;
    #4;
    serve(0, 64'h4000, 13'h40, -1, 1'b1, -1, 64'h0, -1);
    serve(1, 64'h4100, 13'h41, -1, 1'b1, -1, 64'h0, -1);
    serve(0, 64'h4000, 13'h40, -1, 1'b1, -1, 64'h0, -1);
    serve(1, 64'h4100, 13'h41, -1, 1'b1, -1, 64'h0, -1);

    // Gapped response between beats 4 and 5
    do_reset();
    p0_reqcyc = 1'b1; p0_req = 64'h7000; p0_reqtag = 13'h70;
    #4;
    serve(0, 64'h7000, 13'h70, 4, 1'b0, -1, 64'h0, -1);

    // Late dcache request during icache beat 3
    do_reset();
    p0_reqcyc = 1'b1; p0_req = 64'h8000; p0_reqtag = 13'h80;
    #4;
    serve(0, 64'h8000, 13'h80, -1, 1'b0, 2, 64'h9000, -1);
    serve(1, 64'h9000, 13'h19, -1, 1'b0, -1, 64'h0, -1);

    // Reset at beat 5 with a dcache request pending
    do_reset();
    p0_reqcyc = 1'b1; p0_req = 64'hA000; p0_reqtag = 13'hA0;
    #4;
    serve(0, 64'hA000, 13'hA0, -1, 1'b0, 2, 64'hB000, 4);
    serve(1, 64'hB000, 13'h19, -1, 1'b0, -1, 64'h0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
